// File: rtl/stage_if.sv
// Instruction Fetch stage: owns the PC, drives a Wishbone-classic instruction
// port and hands one instruction (or a fetch fault) to decode through a
// one-entry output slot.
module stage_if #(
    parameter logic [31:0] RESET_ADDR = 32'h80000000,
    parameter logic [31:0] NOP_INST   = 32'h00000013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic [31:0] pc_target_i,
    input  logic        stall_i,
    output logic [31:0] iport_addr_o,
    output logic        iport_cyc_o,
    output logic        iport_stb_o,
    input  logic [31:0] iport_dat_i,
    input  logic        iport_ack_i,
    input  logic        iport_err_i,
    output logic [31:0] instruction_o,
    output logic [31:0] pc_o,
    output logic        valid_o,
    output logic        e_inst_access_fault_o,
    output logic        e_inst_misaligned_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_DISCARD = 2'd2,
        S_HALT    = 2'd3
    } state_t;

    state_t      r_state, w_state_next;
    logic [31:0] r_pc, w_pc_next;
    logic [31:0] r_addr, w_addr_next;
    logic        r_cyc, w_cyc_next;
    logic [31:0] r_inst, w_inst_next;
    logic [31:0] r_slot_pc, w_slot_pc_next;
    logic        r_valid, w_valid_next;
    logic        r_fault, w_fault_next;
    logic        r_mis, w_mis_next;

    logic w_consume;
    logic w_slot_free;
    logic w_term;
    logic w_tgt_misaligned;

    assign w_consume        = r_valid && !stall_i;
    assign w_slot_free      = !r_valid || !stall_i;
    assign w_term           = iport_ack_i || iport_err_i;
    assign w_tgt_misaligned = (pc_target_i[1:0] != 2'b00);

    // State, PC, bus and slot registers; reset takes effect immediately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_pc      <= RESET_ADDR;
            r_addr    <= RESET_ADDR;
            r_cyc     <= 1'b0;
            r_inst    <= NOP_INST;
            r_slot_pc <= 32'h0;
            r_valid   <= 1'b0;
            r_fault   <= 1'b0;
            r_mis     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_pc      <= w_pc_next;
            r_addr    <= w_addr_next;
            r_cyc     <= w_cyc_next;
            r_inst    <= w_inst_next;
            r_slot_pc <= w_slot_pc_next;
            r_valid   <= w_valid_next;
            r_fault   <= w_fault_next;
            r_mis     <= w_mis_next;
        end
    end

    // Next-state, PC and slot update; flush outranks stall and consume.
    always_comb begin
        w_state_next   = r_state;
        w_pc_next      = r_pc;
        w_inst_next    = r_inst;
        w_slot_pc_next = r_slot_pc;
        w_valid_next   = r_valid;
        w_fault_next   = r_fault;
        w_mis_next     = r_mis;

        // Default slot behaviour: a consumed entry empties the slot. HALT
        // overrides this below so the faulted entry stays put.
        if (flush_i || w_consume) begin
            w_valid_next = 1'b0;
            w_inst_next  = NOP_INST;
            w_fault_next = 1'b0;
            w_mis_next   = 1'b0;
        end

        case (r_state)
            S_IDLE, S_HALT: begin
                if (flush_i) begin
                    w_pc_next = pc_target_i;
                    if (w_tgt_misaligned) begin
                        // Misaligned target never reaches the bus; it is
                        // reported through the slot and fetch parks.
                        w_slot_pc_next = pc_target_i;
                        w_valid_next   = 1'b1;
                        w_mis_next     = 1'b1;
                        w_state_next   = S_HALT;
                    end else begin
                        w_state_next   = S_IDLE;
                    end
                end else if (r_state == S_HALT) begin
                    w_valid_next = r_valid;
                    w_inst_next  = r_inst;
                    w_fault_next = r_fault;
                    w_mis_next   = r_mis;
                end else if (w_slot_free) begin
                    w_state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                if (flush_i) begin
                    w_pc_next    = pc_target_i;
                    w_state_next = w_term ? S_IDLE : S_DISCARD;
                end else if (iport_ack_i) begin
                    w_inst_next    = iport_dat_i;
                    w_slot_pc_next = r_pc;
                    w_valid_next   = 1'b1;
                    w_fault_next   = 1'b0;
                    w_mis_next     = 1'b0;
                    w_pc_next      = r_pc + 32'd4;
                    w_state_next   = S_IDLE;
                end else if (iport_err_i) begin
                    w_inst_next    = NOP_INST;
                    w_slot_pc_next = r_pc;
                    w_valid_next   = 1'b1;
                    w_fault_next   = 1'b1;
                    w_mis_next     = 1'b0;
                    w_state_next   = S_HALT;
                end
            end
            S_DISCARD: begin
                if (flush_i) begin
                    w_pc_next = pc_target_i;
                end
                if (w_term) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // The bus address tracks the PC except while a killed transfer drains,
    // where it must stay at the address originally presented.
    always_comb begin
        w_cyc_next  = (w_state_next == S_FETCH) || (w_state_next == S_DISCARD);
        w_addr_next = (w_state_next == S_DISCARD) ? r_addr : w_pc_next;
    end

    assign iport_addr_o          = r_addr;
    assign iport_cyc_o           = r_cyc;
    assign iport_stb_o           = r_cyc;
    assign instruction_o         = r_inst;
    assign pc_o                  = r_slot_pc;
    assign valid_o               = r_valid;
    assign e_inst_access_fault_o = r_fault;
    assign e_inst_misaligned_o   = r_mis;

endmodule

// File: tb/tb_stage_if.sv
// Bench for stage_if: directed scenarios with literal expectations followed by
// randomized bus/stall/flush traffic, all checked against a transaction-level
// model of the fetch stage.
module tb_stage_if;

    localparam logic [31:0] RST_A = 32'h80000000;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] tgt = 32'h0;
    logic        stall = 1'b0;
    logic [31:0] addr;
    logic        cyc, stb;
    logic [31:0] dat = 32'h0;
    logic        ack = 1'b0;
    logic        err = 1'b0;
    logic [31:0] inst, pco;
    logic        valid, fault, mis;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    stage_if dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .pc_target_i(tgt),
        .stall_i(stall), .iport_addr_o(addr), .iport_cyc_o(cyc),
        .iport_stb_o(stb), .iport_dat_i(dat), .iport_ack_i(ack),
        .iport_err_i(err), .instruction_o(inst), .pc_o(pco),
        .valid_o(valid), .e_inst_access_fault_o(fault),
        .e_inst_misaligned_o(mis)
    );

    // Model: a bus transfer is outstanding (m_busy) at m_addr, possibly
    // already abandoned (m_disc); m_halt means a fault entry is parked.
    logic [31:0] m_pc, m_addr, m_inst, m_spc;
    logic        m_busy, m_disc, m_halt, m_valid, m_fault, m_mis;

    task automatic model_reset();
        m_pc = RST_A; m_addr = RST_A; m_busy = 0; m_disc = 0; m_halt = 0;
        m_valid = 0; m_inst = NOP; m_spc = 0; m_fault = 0; m_mis = 0;
    endtask

    task automatic slot_clear();
        m_valid = 0; m_inst = NOP; m_fault = 0; m_mis = 0;
    endtask

    task automatic redirect_idle(input logic [31:0] t);
        m_pc = t;
        if (t[1:0] != 2'b00) begin
            m_valid = 1; m_inst = NOP; m_spc = t; m_fault = 0; m_mis = 1;
            m_halt = 1;
        end else begin
            slot_clear();
            m_halt = 0;
        end
    endtask

    task automatic model_step(input logic f, input logic [31:0] t, input logic s,
                              input logic a, input logic e, input logic [31:0] d);
        logic cons;
        cons = m_valid && !s;
        if (m_halt) begin
            if (f) redirect_idle(t);
        end else if (m_busy) begin
            if (a || e)
                $display("xfer addr=%08h %s%s", m_addr, a ? "ack" : "err",
                         (m_disc || f) ? " dropped" : "");
            if (m_disc) begin
                if (f) begin m_pc = t; slot_clear(); end
                else if (cons) slot_clear();
                if (a || e) begin m_busy = 0; m_disc = 0; end
            end else if (f) begin
                slot_clear();
                m_pc = t;
                if (a || e) m_busy = 0; else m_disc = 1;
            end else if (a) begin
                m_valid = 1; m_inst = d; m_spc = m_pc; m_fault = 0; m_mis = 0;
                m_pc = m_pc + 32'd4;
                m_busy = 0;
            end else if (e) begin
                m_valid = 1; m_inst = NOP; m_spc = m_pc; m_fault = 1; m_mis = 0;
                m_halt = 1;
                m_busy = 0;
            end else if (cons) begin
                slot_clear();
            end
        end else begin
            if (f) redirect_idle(t);
            else begin
                if (!m_valid || !s) begin m_busy = 1; m_addr = m_pc; end
                if (cons) slot_clear();
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("cyc",   {31'b0, cyc},   {31'b0, m_busy});
        chk("stb",   {31'b0, stb},   {31'b0, m_busy});
        chk("addr",  addr,           m_busy ? m_addr : m_pc);
        chk("valid", {31'b0, valid}, {31'b0, m_valid});
        chk("inst",  inst,           m_inst);
        chk("pc_o",  pco,            m_spc);
        chk("fault", {31'b0, fault}, {31'b0, m_fault});
        chk("mis",   {31'b0, mis},   {31'b0, m_mis});
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, compare.
    task automatic cyc_step(input logic f, input logic [31:0] t, input logic s,
                            input logic a, input logic e, input logic [31:0] d);
        flush = f; tgt = t; stall = s; ack = a; err = e; dat = d;
        @(posedge clk);
        model_step(f, t, s, a, e, d);
        #1;
        compare_all();
    endtask

    initial begin
        logic        rf, rs, ra, re;
        logic [31:0] rt;

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        chk("rst_addr",  addr, RST_A);
        chk("rst_pc_o",  pco, 32'h0);
        chk("rst_inst",  inst, NOP);
        #3 rst = 1'b0;

        // Reset release, first fetch acked immediately.
        cyc_step(0, 0, 0, 0, 0, 0);
        chk("t1_cyc",  {31'b0, cyc}, 32'd1);
        chk("t1_addr", addr, 32'h80000000);
        cyc_step(0, 0, 1, 1, 0, 32'h00500093);
        chk("t1_valid", {31'b0, valid}, 32'd1);
        chk("t1_inst",  inst, 32'h00500093);
        chk("t1_pco",   pco, 32'h80000000);
        cyc_step(0, 0, 0, 0, 0, 0);
        chk("t1_addr2", addr, 32'h80000004);

        // Live slot held under stall; no fetch until it drains.
        cyc_step(0, 0, 1, 1, 0, 32'h11111111);
        repeat (5) cyc_step(0, 0, 1, 0, 0, 0);
        chk("t2_hold", inst, 32'h11111111);
        cyc_step(0, 0, 0, 0, 0, 0);
        chk("t2_addr", addr, 32'h80000008);

        // Bus error at 0x80000008 parks a fault entry.
        cyc_step(0, 0, 0, 0, 1, 0);
        chk("t5_fault", {31'b0, fault}, 32'd1);
        chk("t5_pco",   pco, 32'h80000008);
        chk("t5_inst",  inst, NOP);
        repeat (10) cyc_step(0, 0, 0, 0, 0, 0);
        cyc_step(1, 32'h80000200, 0, 0, 0, 0);
        cyc_step(0, 0, 0, 0, 0, 0);
        chk("t5_addr", addr, 32'h80000200);

        // Back to idle, then misaligned redirect.
        cyc_step(0, 0, 0, 1, 0, 32'h22222222);
        cyc_step(1, 32'h80000102, 0, 0, 0, 0);
        chk("t6_mis", {31'b0, mis}, 32'd1);
        chk("t6_pco", pco, 32'h80000102);
        chk("t6_cyc", {31'b0, cyc}, 32'd0);
        repeat (3) cyc_step(0, 0, 0, 0, 0, 0);

        // PC wrap at the top of the address space.
        cyc_step(1, 32'hFFFFFFFC, 0, 0, 0, 0);
        cyc_step(0, 0, 0, 0, 0, 0);
        chk("wrap_addr", addr, 32'hFFFFFFFC);
        cyc_step(0, 0, 1, 1, 0, 32'h33333333);
        cyc_step(0, 0, 1, 0, 0, 0);
        cyc_step(0, 0, 0, 0, 0, 0);
        chk("wrap_next", addr, 32'h00000000);

        // Flush during a pending fetch keeps the old address until ack.
        cyc_step(1, 32'h80000100, 0, 0, 0, 0);
        chk("t3_cyc",  {31'b0, cyc}, 32'd1);
        chk("t3_addr", addr, 32'h00000000);
        cyc_step(0, 0, 0, 0, 0, 0);
        cyc_step(0, 0, 0, 1, 0, 32'h44444444);
        chk("t3_valid", {31'b0, valid}, 32'd0);
        cyc_step(0, 0, 0, 0, 0, 0);
        chk("t3_addr2", addr, 32'h80000100);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            rf = ($urandom_range(0, 99) < 8);
            rt = 32'h80000000 | ($urandom & 32'h00000FFC);
            if ($urandom_range(0, 3) == 0) rt[1:0] = 2'($urandom_range(1, 3));
            rs = ($urandom_range(0, 99) < 40);
            ra = m_busy && ($urandom_range(0, 99) < 40);
            re = m_busy && !ra && ($urandom_range(0, 99) < 5);
            cyc_step(rf, rt, rs, ra, re, $urandom);
        end

        // Asynchronous reset in the middle of a fetch.
        cyc_step(1, 32'h80000040, 0, 0, 0, 0);
        cyc_step(0, 0, 0, 0, 0, 0);
        chk("pre_rst_cyc", {31'b0, cyc}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_cyc",  {31'b0, cyc}, 32'd0);
        chk("async_addr", addr, RST_A);
        model_reset();
        #13 rst = 1'b0;
        cyc_step(0, 0, 0, 0, 0, 0);
        chk("refetch_addr", addr, 32'h80000000);
        cyc_step(0, 0, 0, 1, 0, 32'h55555555);
        chk("refetch_pco", pco, 32'h80000000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
